// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types: bus word, memory sequencer states, I/O address default.
package lc3_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef logic [WORD_W-1:0] word16_t;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_t;

    localparam word16_t IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/lc3_wait_counter.sv
// Loadable down-counter with a zero flag; saturates at zero (never wraps).
// Ports:
//   Clk, Reset     clock and synchronous active-high reset
//   load, load_val load counter with load_val (takes priority over dec)
//   dec            decrement by one when nonzero
//   is_zero_c      combinational flag, counter equals zero
module lc3_wait_counter
    import lc3_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_zero_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign is_zero_c = (count == '0);

endmodule

// File: rtl/lc3_mem_access_unit.sv
// LC-3 MAR/MDR pair and SRAM/I/O handshake sequencer.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   bus_in, LD_MAR, LD_MDR     datapath bus and register load strobes
//   mem_start, mem_we          transaction request pulse and direction
//   Switches, mem_rdata        I/O read source and SRAM read data
//   MAR_out, MDR_out           current MAR / MDR
//   mem_ready, busy            completion pulse and in-flight flag
//   mem_addr, mem_wdata        registered SRAM address / write data
//   mem_ce, mem_wr             SRAM chip enable / write strobe
//   hex_disp                   I/O display register
module lc3_mem_access_unit
    import lc3_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter word16_t     IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic    Clk,
    input  logic    Reset,
    input  word16_t bus_in,
    input  logic    LD_MAR,
    input  logic    LD_MDR,
    input  logic    mem_start,
    input  logic    mem_we,
    input  word16_t Switches,
    input  word16_t mem_rdata,
    output word16_t MAR_out,
    output word16_t MDR_out,
    output logic    mem_ready,
    output logic    busy,
    output word16_t mem_addr,
    output word16_t mem_wdata,
    output logic    mem_ce,
    output logic    mem_wr,
    output word16_t hex_disp
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    mem_state_t state, state_nxt;
    word16_t    mar, mdr;
    logic       txn_we;

    logic       cnt_load, cnt_dec, cnt_zero_c;
    logic       start_sram, start_io;
    word16_t    start_addr, wr_data;

    lc3_wait_counter u_wait (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (cnt_load),
        .load_val  (CNT_INIT),
        .dec       (cnt_dec),
        .is_zero_c (cnt_zero_c)
    );

    // Next state and transaction-start decode
    always_comb begin
        state_nxt  = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        start_sram = 1'b0;
        start_io   = 1'b0;
        // Same-cycle LD_MAR / LD_MDR values are forwarded into a new transaction
        start_addr = LD_MAR ? bus_in : mar;
        wr_data    = LD_MDR ? bus_in : mdr;
        case (state)
            MEM_IDLE: begin
                if (mem_start) begin
                    if (start_addr == IO_ADDR) begin
                        start_io  = 1'b1;
                        state_nxt = MEM_DONE;
                    end else begin
                        start_sram = 1'b1;
                        cnt_load   = 1'b1;
                        state_nxt  = MEM_ACCESS;
                    end
                end
            end
            MEM_ACCESS: begin
                if (cnt_zero_c) begin
                    state_nxt = MEM_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            MEM_DONE: state_nxt = MEM_IDLE;
            default:  state_nxt = MEM_IDLE;
        endcase
    end

    // State, MAR/MDR and SRAM/I/O output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= MEM_IDLE;
            mar       <= '0;
            mdr       <= '0;
            txn_we    <= 1'b0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_ce    <= 1'b0;
            mem_wr    <= 1'b0;
            hex_disp  <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != MEM_IDLE);
            mem_ready <= (state_nxt == MEM_DONE);

            if (LD_MAR) begin
                mar <= bus_in;
            end

            case (state)
                MEM_IDLE: begin
                    if (start_sram) begin
                        mem_addr  <= start_addr;
                        mem_wdata <= mem_we ? wr_data : mdr;
                        mem_ce    <= 1'b1;
                        mem_wr    <= mem_we;
                        txn_we    <= mem_we;
                        if (mem_we && LD_MDR) begin
                            mdr <= bus_in;
                        end
                    end else if (start_io) begin
                        if (mem_we) begin
                            hex_disp <= wr_data;
                            if (LD_MDR) begin
                                mdr <= bus_in;
                            end
                        end else begin
                            mdr <= Switches;
                        end
                    end else if (LD_MDR) begin
                        mdr <= bus_in;
                    end
                end
                MEM_ACCESS: begin
                    // Last wait cycle: capture read data and release the SRAM
                    if (cnt_zero_c) begin
                        mem_ce <= 1'b0;
                        mem_wr <= 1'b0;
                        if (!txn_we) begin
                            mdr <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign MAR_out = mar;
    assign MDR_out = mdr;

endmodule
